// File: rtl/uart_tx_fifo_drain.sv
// Read-side sequencer: pops one byte from the TX FIFO per UART frame, enforces an inter-frame
// gap and flags a UART that never goes busy. Define UART_TX_BYTE_CNT_EN to add the BYTE_CNT counter.
module uart_tx_fifo_drain #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned GAP_W      = 8,
   parameter int unsigned BUSY_TO    = 16,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic [GAP_W-1:0]      GAP_CFG,
   input  logic                  R_EMPTY,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  R_INC,
   input  logic                  TX_BUSY,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_DATA_VALID,
   output logic                  TO_ERR
`ifdef UART_TX_BYTE_CNT_EN
   ,
   output logic [CNT_W-1:0]      BYTE_CNT
`endif
);

   localparam int unsigned TO_W = $clog2(BUSY_TO);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SEND    = 3'd2,
      WAIT_HI = 3'd3,
      WAIT_LO = 3'd4,
      GAP     = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
   logic                    to_err_q, to_err_d;
   logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
   logic                    frame_end;
`ifdef UART_TX_BYTE_CNT_EN
   logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
`endif

   always_comb begin
      state_d   = state_q;
      p_data_d  = p_data_q;
      to_err_d  = to_err_q;
      to_cnt_d  = to_cnt_q;
      gap_cnt_d = gap_cnt_q;
      frame_end = 1'b0;
`ifdef UART_TX_BYTE_CNT_EN
      byte_cnt_d = byte_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (EN && !R_EMPTY) state_d = LOAD;
         end
         LOAD: begin
            p_data_d = RD_DATA;
            state_d  = SEND;
         end
         SEND: begin
            to_cnt_d = '0;
            state_d  = WAIT_HI;
         end
         WAIT_HI: begin
            if (TX_BUSY) begin
               state_d = WAIT_LO;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
               // Counter is about to reach BUSY_TO-1: drop the byte and leave as a frame end.
               if (to_cnt_q == TO_W'(BUSY_TO - 2)) begin
                  to_err_d  = 1'b1;
                  frame_end = 1'b1;
               end
            end
         end
         WAIT_LO: begin
            if (!TX_BUSY) begin
               frame_end = 1'b1;
`ifdef UART_TX_BYTE_CNT_EN
               byte_cnt_d = byte_cnt_q + 1'b1;
`endif
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) state_d = IDLE;
            else                 gap_cnt_d = gap_cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (frame_end) begin
         if (GAP_CFG == '0) begin
            state_d = IDLE;
         end else begin
            gap_cnt_d = GAP_CFG - 1'b1;
            state_d   = GAP;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         p_data_q  <= '0;
         to_err_q  <= 1'b0;
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
`ifdef UART_TX_BYTE_CNT_EN
         byte_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         p_data_q  <= p_data_d;
         to_err_q  <= to_err_d;
         to_cnt_q  <= to_cnt_d;
         gap_cnt_q <= gap_cnt_d;
`ifdef UART_TX_BYTE_CNT_EN
         byte_cnt_q <= byte_cnt_d;
`endif
      end
   end

   assign R_INC         = (state_q == LOAD);
   assign TX_DATA_VALID = (state_q == SEND);
   assign TX_P_DATA     = p_data_q;
   assign TO_ERR        = to_err_q;
`ifdef UART_TX_BYTE_CNT_EN
   assign BYTE_CNT      = byte_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with a behavioural FIFO and UART; BYTE_CNT checks
// are compiled in only when UART_TX_BYTE_CNT_EN is defined.
module tb_uart_tx_fifo_drain;

   localparam int DW  = 8;
   localparam int GW  = 8;
   localparam int BTO = 16;
   localparam int CW  = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          EN;
   logic [GW-1:0] GAP_CFG;
   logic          R_EMPTY;
   logic [DW-1:0] RD_DATA;
   logic          R_INC;
   logic          TX_BUSY;
   logic [DW-1:0] TX_P_DATA;
   logic          TX_DATA_VALID;
   logic          TO_ERR;
`ifdef UART_TX_BYTE_CNT_EN
   logic [CW-1:0] BYTE_CNT;
`endif

   int total = 0;
   int bad   = 0;

   uart_tx_fifo_drain #(
      .DATA_WIDTH (DW),
      .GAP_W      (GW),
      .BUSY_TO    (BTO),
      .CNT_W      (CW)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .EN            (EN),
      .GAP_CFG       (GAP_CFG),
      .R_EMPTY       (R_EMPTY),
      .RD_DATA       (RD_DATA),
      .R_INC         (R_INC),
      .TX_BUSY       (TX_BUSY),
      .TX_P_DATA     (TX_P_DATA),
      .TX_DATA_VALID (TX_DATA_VALID),
      .TO_ERR        (TO_ERR)
`ifdef UART_TX_BYTE_CNT_EN
      ,
      .BYTE_CNT      (BYTE_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   // FIFO model: pops one negedge after the R_INC cycle so RD_DATA stays valid through LOAD.
   logic [DW-1:0] fifo_mem [0:63];
   int   wr_ptr = 0;
   int   rd_ptr = 0;
   bit   pop_pend = 1'b0;
   assign R_EMPTY = (wr_ptr == rd_ptr);
   assign RD_DATA = fifo_mem[rd_ptr % 64];

   bit            uart_dead = 1'b0;
   int            ucnt = 1000;
   int            cyc = 0;
   int            nrinc = 0;
   int            nv = 0;
   int            viol = 0;
   logic [DW-1:0] vdata [0:63];
   int            vcyc  [0:63];

   // UART model: BUSY high from 2 to 11 cycles after the VALID cycle (10 cycles) unless dead.
   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (R_INC && R_EMPTY) viol = viol + 1;
      if (pop_pend) begin
         rd_ptr   = rd_ptr + 1;
         pop_pend = 1'b0;
      end
      if (R_INC) begin
         pop_pend = 1'b1;
         nrinc    = nrinc + 1;
      end
      if (TX_DATA_VALID) begin
         vdata[nv % 64] = TX_P_DATA;
         vcyc[nv % 64]  = cyc;
         nv   = nv + 1;
         ucnt = 0;
      end else if (ucnt < 1000) begin
         ucnt = ucnt + 1;
      end
      TX_BUSY = !uart_dead && (ucnt >= 2) && (ucnt <= 11);
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] b);
      fifo_mem[wr_ptr % 64] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (TX_DATA_VALID) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_busy(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (TX_BUSY) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; EN = 1'b0; GAP_CFG = '0;
      tick(); tick();
      total++;
      if (R_INC !== 1'b0 || TX_DATA_VALID !== 1'b0) begin
         bad++; $display("FAIL reset_strobes: got rinc=%b valid=%b want 0 0", R_INC, TX_DATA_VALID);
      end
      total++;
      if (TX_P_DATA !== 8'h00 || TO_ERR !== 1'b0) begin
         bad++; $display("FAIL reset_regs: got pdata=%h to_err=%b want 00 0", TX_P_DATA, TO_ERR);
      end
`ifdef UART_TX_BYTE_CNT_EN
      total++;
      if (BYTE_CNT !== 4'd0) begin
         bad++; $display("FAIL reset_cnt: got %0d want 0", BYTE_CNT);
      end
`endif
      RST = 1'b0;
      tick(); tick();
   endtask

   task automatic test_single();
      int r0;
      int v0;
      r0 = nrinc; v0 = nv;
      push(8'hA5);
      GAP_CFG = '0;
      EN = 1'b1;
      tick();
      total++;
      if (R_INC !== 1'b1 || TX_DATA_VALID !== 1'b0) begin
         bad++; $display("FAIL single_load: got rinc=%b valid=%b want 1 0", R_INC, TX_DATA_VALID);
      end
      tick();
      total++;
      if (R_INC !== 1'b0 || TX_DATA_VALID !== 1'b1) begin
         bad++; $display("FAIL single_send: got rinc=%b valid=%b want 0 1", R_INC, TX_DATA_VALID);
      end
      total++;
      if (TX_P_DATA !== 8'hA5) begin
         bad++; $display("FAIL single_data: got %h want a5", TX_P_DATA);
      end
      repeat (20) tick();
      total++;
      if (nrinc - r0 != 1 || nv - v0 != 1) begin
         bad++; $display("FAIL single_counts: got rinc=%0d valid=%0d want 1 1", nrinc - r0, nv - v0);
      end
      total++;
      if (TX_P_DATA !== 8'hA5) begin
         bad++; $display("FAIL single_hold: got %h want a5", TX_P_DATA);
      end
`ifdef UART_TX_BYTE_CNT_EN
      total++;
      if (BYTE_CNT !== 4'd1) begin
         bad++; $display("FAIL single_cnt: got %0d want 1", BYTE_CNT);
      end
`endif
   endtask

   task automatic test_burst_gap();
      int r0;
      int v0;
      int i;
      r0 = nrinc; v0 = nv;
      GAP_CFG = 8'd3;
      push(8'h01); push(8'h02); push(8'h03);
      i = 0;
      while (nv - v0 < 3 && i < 200) begin
         tick();
         i++;
      end
      total++;
      if (nv - v0 != 3) begin
         bad++; $display("FAIL burst_timeout: got %0d valids want 3", nv - v0);
      end
      repeat (30) tick();
      total++;
      if (vdata[v0 % 64] !== 8'h01 || vdata[(v0 + 1) % 64] !== 8'h02 || vdata[(v0 + 2) % 64] !== 8'h03) begin
         bad++; $display("FAIL burst_order: got %h %h %h want 01 02 03",
                         vdata[v0 % 64], vdata[(v0 + 1) % 64], vdata[(v0 + 2) % 64]);
      end
      // 13 frame cycles + 3 gap + IDLE + LOAD between successive VALIDs
      total++;
      if (vcyc[(v0 + 1) % 64] - vcyc[v0 % 64] != 18 || vcyc[(v0 + 2) % 64] - vcyc[(v0 + 1) % 64] != 18) begin
         bad++; $display("FAIL burst_gap: got spacing %0d %0d want 18 18",
                         vcyc[(v0 + 1) % 64] - vcyc[v0 % 64], vcyc[(v0 + 2) % 64] - vcyc[(v0 + 1) % 64]);
      end
      total++;
      if (nrinc - r0 != 3 || viol != 0) begin
         bad++; $display("FAIL burst_pops: got rinc=%0d empty_pops=%0d want 3 0", nrinc - r0, viol);
      end
   endtask

   task automatic test_timeout();
      bit ok;
`ifdef UART_TX_BYTE_CNT_EN
      logic [CW-1:0] c0;
      c0 = BYTE_CNT;
`endif
      GAP_CFG = '0;
      uart_dead = 1'b1;
      push(8'h5A); push(8'h77);
      wait_valid(ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL timeout_valid: got no VALID want VALID");
      end
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 15) begin
            total++;
            if (TO_ERR !== 1'b0) begin
               bad++; $display("FAIL timeout_early: got to_err=%b want 0 at cycle 15", TO_ERR);
            end
         end
         if (k == 16) begin
            total++;
            if (TO_ERR !== 1'b1) begin
               bad++; $display("FAIL timeout_set: got to_err=%b want 1 at cycle 16", TO_ERR);
            end
            uart_dead = 1'b0;
         end
      end
      total++;
      if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'h77) begin
         bad++; $display("FAIL timeout_next: got valid=%b data=%h want 1 77", TX_DATA_VALID, TX_P_DATA);
      end
      repeat (20) tick();
      total++;
      if (TO_ERR !== 1'b1) begin
         bad++; $display("FAIL timeout_sticky: got %b want 1", TO_ERR);
      end
`ifdef UART_TX_BYTE_CNT_EN
      total++;
      if (BYTE_CNT !== 4'(c0 + 4'd1)) begin
         bad++; $display("FAIL timeout_cnt: got %0d want %0d", BYTE_CNT, 4'(c0 + 4'd1));
      end
`endif
   endtask

   task automatic test_en_drop();
      bit ok;
      int r0;
      r0 = nrinc;
      GAP_CFG = '0;
      push(8'h11); push(8'h22);
      wait_valid(ok);
      wait_busy(ok);
      total++;
      if (!ok) begin
         bad++; $display("FAIL endrop_busy: got no BUSY want BUSY");
      end
      EN = 1'b0;
      repeat (40) tick();
      total++;
      if (nrinc - r0 != 1 || R_EMPTY !== 1'b0) begin
         bad++; $display("FAIL endrop_park: got rinc=%0d empty=%b want 1 0", nrinc - r0, R_EMPTY);
      end
      total++;
      if (TX_P_DATA !== 8'h11) begin
         bad++; $display("FAIL endrop_data: got %h want 11", TX_P_DATA);
      end
      EN = 1'b1;
      wait_valid(ok);
      total++;
      if (!ok || TX_P_DATA !== 8'h22 || nrinc - r0 != 2) begin
         bad++; $display("FAIL endrop_resume: got ok=%b data=%h rinc=%0d want 1 22 2", ok, TX_P_DATA, nrinc - r0);
      end
      repeat (20) tick();
   endtask

   task automatic test_reset_mid();
      bit ok;
      push(8'h3C);
      wait_valid(ok);
      wait_busy(ok);
      repeat (2) tick();
      RST = 1'b1;
      tick();
      total++;
      if (R_INC !== 1'b0 || TX_DATA_VALID !== 1'b0 || TX_P_DATA !== 8'h00 || TO_ERR !== 1'b0) begin
         bad++; $display("FAIL midreset_outs: got rinc=%b valid=%b data=%h to_err=%b want 0 0 00 0",
                         R_INC, TX_DATA_VALID, TX_P_DATA, TO_ERR);
      end
`ifdef UART_TX_BYTE_CNT_EN
      total++;
      if (BYTE_CNT !== 4'd0) begin
         bad++; $display("FAIL midreset_cnt: got %0d want 0", BYTE_CNT);
      end
`endif
      RST = 1'b0;
      EN  = 1'b0;
      repeat (3) tick();
      push(8'hC3);
      EN = 1'b1;
      tick();
      total++;
      if (R_INC !== 1'b1) begin
         bad++; $display("FAIL midreset_idle: got rinc=%b want 1", R_INC);
      end
      tick();
      total++;
      if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'hC3) begin
         bad++; $display("FAIL midreset_send: got valid=%b data=%h want 1 c3", TX_DATA_VALID, TX_P_DATA);
      end
      repeat (20) tick();
   endtask

   task automatic test_back_to_back_wrap();
      int v0;
      int i;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      GAP_CFG = '0;
      EN = 1'b1;
      v0 = nv;
      for (int b = 0; b < 17; b++) push(8'(8'h40 + b));
      i = 0;
      while (nv - v0 < 17 && i < 400) begin
         tick();
         i++;
      end
      total++;
      if (nv - v0 != 17) begin
         bad++; $display("FAIL wrap_frames: got %0d valids want 17", nv - v0);
      end
      repeat (20) tick();
      total++;
      if (vcyc[(v0 + 1) % 64] - vcyc[v0 % 64] != 15) begin
         bad++; $display("FAIL b2b_spacing: got %0d want 15", vcyc[(v0 + 1) % 64] - vcyc[v0 % 64]);
      end
      total++;
      if (vdata[(v0 + 16) % 64] !== 8'h50) begin
         bad++; $display("FAIL wrap_last: got %h want 50", vdata[(v0 + 16) % 64]);
      end
`ifdef UART_TX_BYTE_CNT_EN
      total++;
      if (BYTE_CNT !== 4'd1) begin
         bad++; $display("FAIL wrap_cnt: got %0d want 1", BYTE_CNT);
      end
`endif
   endtask

   initial begin
      RST = 1'b1;
      EN = 1'b0;
      GAP_CFG = '0;
      test_reset();
      test_single();
      test_burst_gap();
      test_timeout();
      test_en_drop();
      test_reset_mid();
      test_back_to_back_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
